// File: rtl/lcd_host_seq.sv
`default_nettype none
// ============================================================================
// lcd_host_seq : host-side command sequencer for the 6x6-image LCD controller
// Revision     : 1.0
// ============================================================================
module lcd_host_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  output logic        req_ready,
  output logic        img_rd,
  output logic [5:0]  img_addr,
  input  logic [7:0]  img_data,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic [7:0]  datain,
  input  logic        lcd_busy,
  input  logic [7:0]  lcd_dout,
  input  logic        lcd_valid,
  output logic [71:0] win_data,
  output logic        done,
  output logic        err
);

  localparam int              c_TW         = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TIMER_MAX  = c_TW'(TIMEOUT);
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_TIMER_ONE  = c_TW'(1);
  localparam logic [2:0]      c_OP_LOAD    = 3'd1;
  localparam logic [2:0]      c_OP_LAST    = 3'd5;
  localparam logic [5:0]      c_ADDR_LAST  = 6'd35;
  localparam logic [5:0]      c_ADDR_ONE   = 6'd1;
  localparam logic [3:0]      c_CNT_LAST   = 4'd8;
  localparam logic [3:0]      c_CNT_ONE    = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_ISSUE     = 3'd2,
    S_STREAM    = 3'd3,
    S_CAPTURE   = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op, w_op_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [5:0]      r_addr, w_addr_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic            r_rd, w_rd_nxt;
  logic            r_rd_d;
  logic [2:0]      r_cmd, w_cmd_nxt;
  logic            r_cmd_valid, w_cmd_valid_nxt;
  logic [71:0]     r_win, w_win_nxt;
  logic            r_err, w_err_nxt;
  logic            r_done;
  logic            r_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_timer_nxt     = r_timer;
    w_rd_nxt        = 1'b0;
    w_cmd_nxt       = 3'd0;
    w_cmd_valid_nxt = 1'b0;
    w_win_nxt       = r_win;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_op_nxt    = req_op;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = 4'd0;
          w_timer_nxt = '0;
          if (req_op > c_OP_LAST) begin
            w_state_nxt = S_FINISH;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Outputs are registered, so the ISSUE-cycle strobes are set up here.
        if (!lcd_busy) begin
          w_state_nxt     = S_ISSUE;
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = r_op;
          if (r_op == c_OP_LOAD) begin
            w_rd_nxt   = 1'b1;
            w_addr_nxt = 6'd0;
          end
        end else if (r_timer >= c_TIMER_LAST) begin
          w_state_nxt = S_FINISH;
          w_err_nxt   = 1'b1;
          w_timer_nxt = c_TIMER_MAX;
        end else begin
          w_timer_nxt = r_timer + c_TIMER_ONE;
        end
      end
      S_ISSUE: begin
        if (r_op == c_OP_LOAD) begin
          w_state_nxt = S_STREAM;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = c_ADDR_ONE;
        end else begin
          w_state_nxt = S_CAPTURE;
          w_timer_nxt = '0;
        end
      end
      S_STREAM: begin
        // One extra cycle with img_rd low lets the last read byte reach datain.
        if (r_rd) begin
          if (r_addr != c_ADDR_LAST) begin
            w_rd_nxt   = 1'b1;
            w_addr_nxt = r_addr + c_ADDR_ONE;
          end
        end else begin
          w_state_nxt = S_CAPTURE;
          w_timer_nxt = '0;
          w_addr_nxt  = 6'd0;
        end
      end
      S_CAPTURE: begin
        if (lcd_valid) begin
          for (int i = 0; i < 9; i++) begin
            if (r_cnt == 4'(i)) w_win_nxt[8*i +: 8] = lcd_dout;
          end
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
          w_timer_nxt = '0;
          if (r_cnt == c_CNT_LAST) w_state_nxt = S_FINISH;
        end else if (r_timer >= c_TIMER_LAST) begin
          w_state_nxt = S_FINISH;
          w_err_nxt   = 1'b1;
          w_timer_nxt = c_TIMER_MAX;
        end else begin
          w_timer_nxt = r_timer + c_TIMER_ONE;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_cnt       <= 4'd0;
      r_addr      <= 6'd0;
      r_timer     <= '0;
      r_rd        <= 1'b0;
      r_rd_d      <= 1'b0;
      r_cmd       <= 3'd0;
      r_cmd_valid <= 1'b0;
      r_win       <= 72'd0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_timer     <= w_timer_nxt;
      r_rd        <= w_rd_nxt;
      r_rd_d      <= r_rd;
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_win       <= w_win_nxt;
      r_err       <= w_err_nxt;
      r_done      <= (w_state_nxt == S_FINISH);
      r_ready     <= (w_state_nxt == S_IDLE);
    end
  end

  assign req_ready = r_ready;
  assign img_rd    = r_rd;
  assign img_addr  = r_addr;
  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign datain    = r_rd_d ? img_data : 8'd0;
  assign win_data  = r_win;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_host_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_lcd_host_seq : randomized self-checking bench with a request-level model
// Revision        : 1.0
// ============================================================================
module tb_lcd_host_seq;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic        req_ready;
  logic        img_rd;
  logic [5:0]  img_addr;
  logic [7:0]  img_data = 8'd0;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  datain;
  logic        lcd_busy = 1'b0;
  logic [7:0]  lcd_dout = 8'd0;
  logic        lcd_valid = 1'b0;
  logic [71:0] win_data;
  logic        done;
  logic        err;

  lcd_host_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain),
    .lcd_busy(lcd_busy), .lcd_dout(lcd_dout), .lcd_valid(lcd_valid),
    .win_data(win_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Source memory with one cycle of read latency.
  logic [7:0] mem [36];
  always @(posedge clk) if (img_rd && img_addr < 6'd36) img_data <= mem[img_addr];

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  stim [9];
  logic [71:0] exp_win;

  // Observations gathered by the request driver.
  int          ob_accept_ok, ob_ready1, ob_err1;
  int          ob_cmd_n, ob_cmd_cnt, ob_rd_cnt, ob_b2b, ob_busy_cmd;
  logic [2:0]  ob_cmd;
  logic [7:0]  ob_din [36];
  int          ob_done_n, ob_done_cnt, ob_last_send;
  logic        ob_done_err, ob_ready_after, ob_done_after;
  logic [71:0] ob_win;

  // Expected window: previous contents with the first nfill slots replaced
  // by the bytes the LCD model sent, in arrival order.
  function automatic logic [71:0] model_win(input int nfill, input logic [71:0] prev);
    logic [71:0] w;
    w = prev;
    for (int i = 0; i < nfill; i++) w[8*i +: 8] = stim[i];
    return w;
  endfunction

  // Issues one request and plays the LCD controller; records what it sees.
  task automatic drive_req(input logic [2:0] op, input int busy_cyc, input int nsend,
                           input int gap_max, input bit junk);
    int  n, sent, nxt;
    bit  fin, prev_cv;
    ob_cmd_n = -1; ob_cmd_cnt = 0; ob_rd_cnt = 0; ob_b2b = 0; ob_busy_cmd = 0;
    ob_done_n = -1; ob_done_cnt = 0; ob_last_send = -1; ob_cmd = 3'd0;
    ob_done_err = 1'b0; ob_ready_after = 1'b0; ob_done_after = 1'b1; ob_win = '0;
    for (int i = 0; i < 36; i++) ob_din[i] = 8'hxx;
    sent = 0; nxt = -1; fin = 0; prev_cv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; lcd_valid = 1'b0; lcd_busy = 1'b0;
    ob_accept_ok = int'(req_ready);
    for (n = 1; n < 400 && !fin; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      lcd_busy  = (n <= busy_cyc);
      lcd_valid = 1'b0;
      lcd_dout  = 8'($urandom);
      if (nxt > 0 && sent < nsend && n == nxt) begin
        lcd_valid = 1'b1; lcd_dout = stim[sent]; sent++;
        ob_last_send = n;
        nxt = n + 1 + int'($urandom_range(0, gap_max));
      end else if (junk && (ob_cmd_n < 0 || (op == 3'd1 && n < ob_cmd_n + 37))
                   && $urandom_range(0, 2) == 0) begin
        lcd_valid = 1'b1;
      end else if (junk && sent == nsend && n == ob_last_send + 1) begin
        lcd_valid = 1'b1;
      end
      if (n == 1) begin ob_ready1 = int'(req_ready); ob_err1 = int'(err); end
      if (cmd_valid) begin
        ob_cmd_cnt++; ob_cmd_n = n; ob_cmd = cmd;
        if (prev_cv) ob_b2b++;
        if (lcd_busy) ob_busy_cmd++;
        nxt = n + ((op == 3'd1) ? 37 : 1) + int'($urandom_range(0, gap_max));
      end
      prev_cv = cmd_valid;
      if (img_rd) ob_rd_cnt++;
      if (ob_cmd_n > 0 && n > ob_cmd_n && n <= ob_cmd_n + 36) ob_din[n-ob_cmd_n-1] = datain;
      if (ob_done_n > 0 && n == ob_done_n + 1) begin
        ob_ready_after = req_ready; ob_done_after = done; fin = 1;
      end else if (done) begin
        ob_done_cnt++; ob_done_n = n; ob_done_err = err; ob_win = win_data;
      end
    end
    lcd_valid = 1'b0; lcd_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({req_ready, cmd_valid, img_rd, done, err} !== 5'b10000) begin n_fail++;
      $display("FAIL reset_flags: got %b want 10000", {req_ready, cmd_valid, img_rd, done, err}); end
    n_cmp++; if ({cmd, img_addr, datain} !== 17'd0) begin n_fail++;
      $display("FAIL reset_buses: got cmd=%0d addr=%0d datain=%0d want 0", cmd, img_addr, datain); end
    n_cmp++; if (win_data !== 72'd0) begin n_fail++;
      $display("FAIL reset_win: got %h want 0", win_data); end
    reset_n = 1'b1;
    exp_win = 72'd0;
  endtask

  task automatic test_load();
    int bad;
    for (int a = 0; a < 36; a++) mem[a] = 8'(a);
    stim = '{8'd14, 8'd15, 8'd16, 8'd20, 8'd21, 8'd22, 8'd26, 8'd27, 8'd28};
    drive_req(3'd1, 0, 9, 3, 1'b1);
    n_cmp++; if (ob_accept_ok != 1 || ob_ready1 != 0) begin n_fail++;
      $display("FAIL load_ready: got accept=%0d ready_after_accept=%0d want 1/0", ob_accept_ok, ob_ready1); end
    n_cmp++; if (ob_cmd_n != 2 || ob_cmd !== 3'd1 || ob_cmd_cnt != 1) begin n_fail++;
      $display("FAIL load_issue: got cycle=%0d cmd=%0d count=%0d want 2/1/1", ob_cmd_n, ob_cmd, ob_cmd_cnt); end
    n_cmp++; if (ob_rd_cnt != 36) begin n_fail++;
      $display("FAIL load_reads: got %0d want 36", ob_rd_cnt); end
    bad = 0;
    for (int k = 0; k < 36; k++) if (ob_din[k] !== mem[k]) bad++;
    n_cmp++; if (bad != 0) begin n_fail++;
      $display("FAIL load_datain: got %0d wrong bytes (byte0=%0d byte35=%0d) want 0", bad, ob_din[0], ob_din[35]); end
    n_cmp++; if (ob_done_cnt != 1 || ob_done_n != ob_last_send + 1 || ob_done_after !== 1'b0) begin n_fail++;
      $display("FAIL load_done: got pulses=%0d at=%0d want 1 at %0d", ob_done_cnt, ob_done_n, ob_last_send + 1); end
    n_cmp++; if (ob_win !== 72'h1c1b1a161514100f0e || ob_done_err !== 1'b0) begin n_fail++;
      $display("FAIL load_win: got %h err=%b want 1c1b1a161514100f0e err=0", ob_win, ob_done_err); end
    n_cmp++; if (ob_ready_after !== 1'b1 || ob_b2b != 0) begin n_fail++;
      $display("FAIL load_tail: got ready=%b b2b=%0d want 1/0", ob_ready_after, ob_b2b); end
    exp_win = 72'h1c1b1a161514100f0e;
  endtask

  task automatic test_shift_r();
    stim = '{8'd15, 8'd16, 8'd17, 8'd21, 8'd22, 8'd23, 8'd27, 8'd28, 8'd29};
    drive_req(3'd2, 0, 9, 2, 1'b1);
    n_cmp++; if (ob_cmd_cnt != 1 || ob_cmd !== 3'd2 || ob_rd_cnt != 0) begin n_fail++;
      $display("FAIL shiftr_cmd: got count=%0d cmd=%0d reads=%0d want 1/2/0", ob_cmd_cnt, ob_cmd, ob_rd_cnt); end
    n_cmp++; if (ob_win !== 72'h1d1c1b17161511100f || ob_done_err !== 1'b0 || ob_done_cnt != 1) begin n_fail++;
      $display("FAIL shiftr_win: got %h err=%b done=%0d want 1d1c1b17161511100f/0/1", ob_win, ob_done_err, ob_done_cnt); end
    exp_win = 72'h1d1c1b17161511100f;
  endtask

  task automatic test_busy_hold();
    for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
    drive_req(3'd0, 20, 9, 2, 1'b1);
    n_cmp++; if (ob_cmd_n != 22 || ob_cmd_cnt != 1 || ob_busy_cmd != 0) begin n_fail++;
      $display("FAIL busy_issue: got cycle=%0d count=%0d under_busy=%0d want 22/1/0", ob_cmd_n, ob_cmd_cnt, ob_busy_cmd); end
    n_cmp++; if (ob_win !== model_win(9, exp_win) || ob_done_err !== 1'b0) begin n_fail++;
      $display("FAIL busy_win: got %h err=%b want %h err=0", ob_win, ob_done_err, model_win(9, exp_win)); end
    exp_win = model_win(9, exp_win);
  endtask

  task automatic test_timeout();
    int lat;
    for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
    drive_req(3'd3, 0, 5, 3, 1'b0);
    lat = ob_done_n - ob_last_send;
    n_cmp++; if (ob_done_cnt != 1 || lat < TO || lat > TO + 1 || ob_done_err !== 1'b1) begin n_fail++;
      $display("FAIL timeout_done: got pulses=%0d latency=%0d err=%b want 1/%0d..%0d/1",
               ob_done_cnt, lat, ob_done_err, TO, TO + 1); end
    n_cmp++; if (ob_win !== model_win(5, exp_win)) begin n_fail++;
      $display("FAIL timeout_slots: got %h want %h", ob_win, model_win(5, exp_win)); end
    exp_win = model_win(5, exp_win);
  endtask

  task automatic test_illegal();
    drive_req(3'd7, 0, 9, 1, 1'b1);
    n_cmp++; if (ob_cmd_cnt != 0 || ob_rd_cnt != 0) begin n_fail++;
      $display("FAIL illegal_cmd: got cmd_valid=%0d reads=%0d want 0/0", ob_cmd_cnt, ob_rd_cnt); end
    n_cmp++; if (ob_done_cnt != 1 || ob_done_n < 1 || ob_done_n > 2 || ob_done_err !== 1'b1) begin n_fail++;
      $display("FAIL illegal_done: got pulses=%0d at=%0d err=%b want 1 at 1..2 err=1", ob_done_cnt, ob_done_n, ob_done_err); end
    n_cmp++; if (ob_win !== exp_win) begin n_fail++;
      $display("FAIL illegal_win: got %h want %h", ob_win, exp_win); end
    for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
    drive_req(3'd4, 0, 9, 2, 1'b0);
    n_cmp++; if (ob_err1 != 0 || ob_done_err !== 1'b0 || ob_cmd !== 3'd4) begin n_fail++;
      $display("FAIL illegal_clear: got err_after_accept=%0d err_done=%b cmd=%0d want 0/0/4", ob_err1, ob_done_err, ob_cmd); end
    exp_win = model_win(9, exp_win);
  endtask

  task automatic test_random();
    logic [2:0] op;
    int busy, bad;
    for (int it = 0; it < 5; it++) begin
      op   = 3'($urandom_range(0, 5));
      busy = int'($urandom_range(0, 10));
      for (int a = 0; a < 36; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
      drive_req(op, busy, 9, 3, 1'b1);
      bad = 0;
      if (op == 3'd1) for (int k = 0; k < 36; k++) if (ob_din[k] !== mem[k]) bad++;
      n_cmp++; if (ob_cmd_n != busy + 2 || ob_cmd !== op || ob_cmd_cnt != 1 || ob_b2b != 0) begin n_fail++;
        $display("FAIL rand_issue[%0d]: got cycle=%0d cmd=%0d count=%0d want %0d/%0d/1",
                 it, ob_cmd_n, ob_cmd, ob_cmd_cnt, busy + 2, op); end
      n_cmp++; if (ob_rd_cnt != ((op == 3'd1) ? 36 : 0) || bad != 0) begin n_fail++;
        $display("FAIL rand_stream[%0d]: got reads=%0d bad_bytes=%0d op=%0d", it, ob_rd_cnt, bad, op); end
      n_cmp++; if (ob_win !== model_win(9, exp_win) || ob_done_err !== 1'b0 || ob_done_n != ob_last_send + 1) begin n_fail++;
        $display("FAIL rand_win[%0d]: got %h err=%b done_at=%0d want %h err=0 at %0d",
                 it, ob_win, ob_done_err, ob_done_n, model_win(9, exp_win), ob_last_send + 1); end
      exp_win = model_win(9, exp_win);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n, t0, bad;
    for (int a = 0; a < 36; a++) mem[a] = 8'($urandom);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; lcd_busy = 1'b0; lcd_valid = 1'b0;
    n = 0; t0 = -1;
    while (n < 60) begin
      @(negedge clk); n++;
      req_valid = 1'b0;
      if (cmd_valid && t0 < 0) t0 = n;
      if (t0 > 0 && n == t0 + 18) break;
    end
    n_cmp++; if (t0 < 0 || n != t0 + 18 || datain !== mem[17]) begin n_fail++;
      $display("FAIL rst_byte17: got datain=%0d at %0d want %0d", datain, n, mem[17]); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if ({req_ready, cmd_valid, img_rd, done, err} !== 5'b10000 ||
                 {cmd, img_addr, datain} !== 17'd0 || win_data !== 72'd0) begin n_fail++;
      $display("FAIL rst_async: got flags=%b cmd=%0d addr=%0d datain=%0d win=%h want reset values",
               {req_ready, cmd_valid, img_rd, done, err}, cmd, img_addr, datain, win_data); end
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_hold: got done=%b ready=%b want 0/1", done, req_ready); end
    reset_n = 1'b1;
    exp_win = 72'd0;
    for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
    drive_req(3'd1, 0, 9, 2, 1'b1);
    bad = 0;
    for (int k = 0; k < 36; k++) if (ob_din[k] !== mem[k]) bad++;
    n_cmp++; if (bad != 0 || ob_cmd_n != 2 || ob_rd_cnt != 36) begin n_fail++;
      $display("FAIL rst_reload_stream: got bad=%0d issue=%0d reads=%0d want 0/2/36", bad, ob_cmd_n, ob_rd_cnt); end
    n_cmp++; if (ob_win !== model_win(9, exp_win) || ob_done_cnt != 1 || ob_done_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_reload_win: got %h done=%0d err=%b want %h/1/0",
               ob_win, ob_done_cnt, ob_done_err, model_win(9, exp_win)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_load();
    test_shift_r();
    test_busy_hold();
    test_timeout();
    test_illegal();
    test_random();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
